// File: rtl/simple_fetch_pkg.sv
// rtl/simple_fetch_pkg.sv - shared widths, default reset PC and queue entry type for the fetch stage
package simple_fetch_pkg;
  localparam int INST_W = 16;
  localparam int PC_W   = 16;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry prefetch queue of {pc, inst}; flush beats push and pop
module fetch_fifo
  import simple_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);
  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/simple_fetch_unit.sv
// rtl/simple_fetch_unit.sv - fetch stage top: PC, credit, in-flight tracking; FETCH_STATS_EN adds fetch/flush counters
module simple_fetch_unit
  import simple_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              halt,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [PC_W-1:0]   id_pc,
  output logic [PC_W-1:0]   id_pc_plus1,
  output logic              busy
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [7:0]        flush_count
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0] fetch_pc;
  logic [PC_W-1:0] inflight_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic            credit;
  logic            push;
  logic            pop;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  // An in-flight read already owns a slot, so a push can never hit a full queue.
  assign credit    = (count + CW'(inflight)) < CW'(DEPTH);
  assign imem_req  = ce && !halt && !redirect && !rst && credit;
  assign imem_addr = fetch_pc;

  assign push      = inflight && !redirect;
  assign push_data = '{pc: inflight_pc, inst: imem_rdata};
  assign pop       = id_valid && id_ready && !redirect;

  assign id_valid    = (count != '0);
  assign id_inst     = head.inst;
  assign id_pc       = head.pc;
  assign id_pc_plus1 = head.pc + PC_W'(1);
  assign busy        = id_valid || inflight;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else if (imem_req) begin
      inflight_pc <= fetch_pc;
      fetch_pc    <= fetch_pc + PC_W'(1);
      inflight    <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (push && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      if (redirect && (id_valid || inflight) && flush_count != 8'hFF)
        flush_count <= flush_count + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_simple_fetch_unit.sv
// tb/tb_simple_fetch_unit.sv - directed bench for simple_fetch_unit with a delivery scoreboard
module tb_simple_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        halt = 1'b0;
  logic        redirect = 1'b0;
  logic        id_ready = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic [15:0] imem_rdata = 16'h0;
  logic        imem_req;
  logic        id_valid;
  logic        busy;
  logic [15:0] imem_addr;
  logic [15:0] id_inst;
  logic [15:0] id_pc;
  logic [15:0] id_pc_plus1;
`ifdef FETCH_STATS_EN
  logic [15:0] fetch_count;
  logic [7:0]  flush_count;
`endif

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  int reqs = 0;
  logic saw_req;
  logic [15:0] mon_pc;
  logic [15:0] sb[$];

  simple_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .ce          (ce),
    .halt        (halt),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_pc_plus1 (id_pc_plus1),
    .busy        (busy)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count (fetch_count),
    .flush_count (flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Instruction RAM: word at address a is a + 16'hA000, one cycle latency.
  always @(posedge clk) if (imem_req) imem_rdata <= imem_addr + 16'hA000;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_sb(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) sb.push_back(start + 16'(i));
  endtask

  always @(negedge clk) begin
    if (!rst && !redirect && id_valid && id_ready) begin
      delivered++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_empty observed pc %h expected no delivery", id_pc);
      end
      if (sb.size() != 0) begin
        mon_pc = sb.pop_front();
        chk("pop_pc", id_pc, mon_pc);
        chk("pop_inst", id_inst, mon_pc + 16'hA000);
        chk("pop_plus1", id_pc_plus1, mon_pc + 16'd1);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    next(); next(); #2;
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", id_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk("rst_inst", id_inst, 16'h0);
    chk("rst_pc", id_pc, 16'h0);
`ifdef FETCH_STATS_EN
    chk("rst_fetch_count", fetch_count, 16'h0);
    chk("rst_flush_count", {8'h0, flush_count}, 16'h0);
`endif

    // streaming from reset
    next(); rst = 1'b0; ce = 1'b1; id_ready = 1'b1; sb.delete(); fill_sb(16'h0, 16); delivered = 0; #2;
    chk1("c0_req", imem_req, 1'b1);
    chk("c0_addr", imem_addr, 16'h0000);
    chk1("c0_valid", id_valid, 1'b0);
    next(); #2;
    chk("c1_addr", imem_addr, 16'h0001);
    chk1("c1_valid", id_valid, 1'b0);
    next(); #2;
    chk1("c2_valid", id_valid, 1'b1);
    chk("c2_inst", id_inst, 16'hA000);
    chk("c2_pc", id_pc, 16'h0000);
    chk("c2_plus1", id_pc_plus1, 16'h0001);
    chk("c2_addr", imem_addr, 16'h0002);
    for (int i = 3; i < 9; i++) begin
      next(); #2;
      chk1("stream_valid", id_valid, 1'b1);
    end
    next();
    chk("stream_count", 16'(delivered), 16'd7);

    // backpressure: credits stop issue at DEPTH
    rst = 1'b1; id_ready = 1'b0;
    next(); rst = 1'b0; sb.delete(); fill_sb(16'h0, 16); delivered = 0; reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) next();
      #2;
      reqs += int'(imem_req);
      if (i < 4) chk("bp_addr", imem_addr, 16'(i));
    end
    chk("bp_reqs", 16'(reqs), 16'd4);
    chk1("bp_req_off", imem_req, 1'b0);
    chk1("bp_valid", id_valid, 1'b1);
    next(); id_ready = 1'b1; #2;
    chk1("bp_hold", imem_req, 1'b0);
    next(); #2;
    chk1("bp_restart", imem_req, 1'b1);
    chk("bp_restart_addr", imem_addr, 16'h0004);
    for (int i = 0; i < 6; i++) next();
    next();
    chk("bp_delivered", 16'(delivered), 16'd8);

    // redirect with 3 queued and 1 in flight
    rst = 1'b1; id_ready = 1'b0;
    next(); rst = 1'b0; sb.delete(); delivered = 0;
    next(); next(); next();
    next(); redirect = 1'b1; redirect_pc = 16'h0040; id_ready = 1'b1; fill_sb(16'h0040, 8); #2;
    chk1("rd_req_r", imem_req, 1'b0);
    chk1("rd_valid_r", id_valid, 1'b1);
    next(); redirect = 1'b0; #2;
    chk1("rd_valid_r1", id_valid, 1'b0);
    chk1("rd_req_r1", imem_req, 1'b1);
    chk("rd_addr_r1", imem_addr, 16'h0040);
`ifdef FETCH_STATS_EN
    chk("rd_flush_count", {8'h0, flush_count}, 16'd1);
    chk("rd_fetch_count", fetch_count, 16'd3);
`endif
    next(); #2;
    chk1("rd_valid_r2", id_valid, 1'b0);
    chk("rd_addr_r2", imem_addr, 16'h0041);
    next(); #2;
    chk1("rd_valid_r3", id_valid, 1'b1);
    chk("rd_pc_r3", id_pc, 16'h0040);
    chk("rd_inst_r3", id_inst, 16'hA040);

    // PC wrap, then halt mid-stream
    next(); redirect = 1'b1; redirect_pc = 16'hFFFE; sb.delete(); fill_sb(16'hFFFE, 3); delivered = 0; #2;
    chk1("wr_req_r", imem_req, 1'b0);
    next(); redirect = 1'b0; #2;
    chk1("wr_req_1", imem_req, 1'b1);
    chk("wr_addr_1", imem_addr, 16'hFFFE);
    next(); #2;
    chk("wr_addr_2", imem_addr, 16'hFFFF);
    next(); #2;
    chk1("wr_req_3", imem_req, 1'b1);
    chk("wr_addr_3", imem_addr, 16'h0000);
    next(); halt = 1'b1; #2;
    chk1("halt_req", imem_req, 1'b0);
    saw_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      next(); #2;
      if (imem_req) saw_req = 1'b1;
      if (!busy) break;
    end
    chk1("halt_noreq", saw_req, 1'b0);
    chk1("halt_busy", busy, 1'b0);
    chk("halt_drained", 16'(delivered), 16'd3);
    next(); halt = 1'b0; fill_sb(16'h0001, 8); #2;
    chk1("resume_req", imem_req, 1'b1);
    chk("resume_addr", imem_addr, 16'h0001);
    next(); next(); next();

    // reset with a full queue
    next(); id_ready = 1'b0;
    for (int i = 0; i < 6; i++) next();
    #2;
    chk1("full_valid", id_valid, 1'b1);
    chk1("full_req", imem_req, 1'b0);
    next(); rst = 1'b1; id_ready = 1'b1;
    next(); rst = 1'b0; ce = 1'b0; sb.delete(); delivered = 0; #2;
    chk1("rr_valid", id_valid, 1'b0);
    chk1("rr_busy", busy, 1'b0);
    chk("rr_addr", imem_addr, 16'h0000);
    chk1("rr_req", imem_req, 1'b0);
`ifdef FETCH_STATS_EN
    chk("rr_fetch_count", fetch_count, 16'h0);
    chk("rr_flush_count", {8'h0, flush_count}, 16'h0);
`endif
    next(); ce = 1'b1; fill_sb(16'h0, 4); #2;
    chk1("rr_req_ce", imem_req, 1'b1);
    chk("rr_addr_ce", imem_addr, 16'h0000);
    next(); next(); #2;
    chk1("rr_valid2", id_valid, 1'b1);
    chk("rr_pc2", id_pc, 16'h0000);
    next(); next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
